comp_driver: RTL and testbench

COMP_DRIVER -- requirements
Module: comp_driver

---
 rtl/comp_driver.sv | 131 +++++++++++++
 tb/tb_comp_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/comp_driver.sv
// comp_driver: exhaustive 4-bit comparator sweep driver with mismatch counting
//
// Drives all 256 (a, b) operand pairs, A-major and B-minor, into an external
// comparator. Each pair is held for settle_cyc cycles and then its {st, eq, lt}
// result is checked against an internally computed reference.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle sweep request, accepted only when idle or done
//   abort    in   ends an active sweep; err_cnt is kept
//   a, b     out  operands driven to the comparator under test
//   st/eq/lt in   comparator result: a<b, a==b, a>b
//   busy     out  sweep in progress
//   done     out  sweep complete, held until the next start or reset
//   pass     out  done with no mismatches
//   err_cnt  out  mismatching pairs in the current or last sweep
//   fail_a/b out  operands of the first failing pair
//
// Build option: define COMP_DRV_FAILLOG_EN to capture the first failing pair
// into fail_a/fail_b. Without it both outputs are tied to zero.
module comp_driver #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] a,
    output logic [3:0] b,
    input  logic       st,
    input  logic       eq,
    input  logic       lt,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic [3:0] fail_a,
    output logic [3:0] fail_b
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE_ST} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state, state_nx;
    logic [7:0] idx;
    logic [3:0] cnt;
    logic       accept;
    logic       kill;
    logic       mismatch;

    assign busy     = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
    assign accept   = start && ((state == IDLE) || (state == DONE_ST));
    assign kill     = abort && busy;
    assign mismatch = {st, eq, lt} != {a < b, a == b, a > b};
    assign pass     = done && (err_cnt == 9'd0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE_ST: state_nx = start ? DRIVE : state;
            DRIVE:         state_nx = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
            SETTLE:        state_nx = (cnt == SETTLE_LAST) ? SAMPLE : SETTLE;
            SAMPLE:        state_nx = (idx == 8'hff) ? DONE_ST : DRIVE;
            default:       state_nx = IDLE;
        endcase
        if (kill)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            idx     <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            if (kill) begin
                // abort wins over any sample update in the same cycle
                a    <= '0;
                b    <= '0;
                done <= 1'b0;
            end else if (accept) begin
                idx     <= '0;
                err_cnt <= '0;
                done    <= 1'b0;
            end else begin
                case (state)
                    DRIVE: begin
                        a   <= idx[7:4];
                        b   <= idx[3:0];
                        cnt <= '0;
                    end
                    SETTLE: cnt <= cnt + 4'd1;
                    SAMPLE: begin
                        if (mismatch && err_cnt != 9'd256)
                            err_cnt <= err_cnt + 9'd1;
                        if (idx != 8'hff)
                            idx <= idx + 8'd1;
                    end
                    // done is registered one cycle after entering DONE_ST
                    DONE_ST: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef COMP_DRV_FAILLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a <= '0;
            fail_b <= '0;
        end else if (accept) begin
            fail_a <= '0;
            fail_b <= '0;
        end else if (state == SAMPLE && !abort && mismatch && err_cnt == 9'd0) begin
            fail_a <= a;
            fail_b <= b;
        end
    end
`else
    assign fail_a = 4'd0;
    assign fail_b = 4'd0;
`endif

endmodule

// File: tb/tb_comp_driver.sv
// tb_comp_driver: scoreboard bench for comp_driver with behavioural comparator models
module tb_comp_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic       st0, eq0, lt0, st1, eq1, lt1;
    logic [3:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [8:0] err0, err1;
    int         mode0 = 0;
    int         mode1 = 2;
    int         checks = 0;
    int         failures = 0;

`ifdef COMP_DRV_FAILLOG_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        string tag;
        int    lat;
        int    err;
        int    pass;
        int    fa;
        int    fb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    comp_driver #(.SETTLE_CYC(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .st(st0), .eq(eq0), .lt(lt0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_a(fa0), .fail_b(fb0)
    );

    comp_driver #(.SETTLE_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .st(st1), .eq(eq1), .lt(lt1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_a(fa1), .fail_b(fb1)
    );

    // mode 0 ideal, 1 eq stuck high, 2 st and lt swapped
    always_comb begin
        st0 = (mode0 == 2) ? (a0 > b0) : (a0 < b0);
        eq0 = (mode0 == 1) ? 1'b1 : (a0 == b0);
        lt0 = (mode0 == 2) ? (a0 < b0) : (a0 > b0);
        st1 = (mode1 == 2) ? (a1 > b1) : (a1 < b1);
        eq1 = (mode1 == 1) ? 1'b1 : (a1 == b1);
        lt1 = (mode1 == 2) ? (a1 < b1) : (a1 > b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] err_of(input int d);
        return d ? err1 : err0;
    endfunction
    function automatic logic done_of(input int d);
        return d ? done1 : done0;
    endfunction
    function automatic logic busy_of(input int d);
        return d ? busy1 : busy0;
    endfunction
    function automatic logic pass_of(input int d);
        return d ? pass1 : pass0;
    endfunction
    function automatic logic [3:0] fa_of(input int d);
        return d ? fa1 : fa0;
    endfunction
    function automatic logic [3:0] fb_of(input int d);
        return d ? fb1 : fb0;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d != 0) start1 = v;
        else start0 = v;
    endtask

    // start a sweep, optionally re-pulse start at cycle rp, and score it at done
    task automatic run_sweep(input int d, input int rp);
        exp_t e;
        int   cnt = 0;
        @(negedge clk) set_start(d, 1'b1);
        @(posedge clk);
        @(negedge clk) set_start(d, 1'b0);
        chk("busy_on", busy_of(d), 1);
        chk("done_clr", done_of(d), 0);
        while (!done_of(d) && cnt < 5000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            set_start(d, cnt == rp);
        end
        set_start(d, 1'b0);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_lat"}, cnt, e.lat);
            chk({e.tag, "_err"}, err_of(d), e.err);
            chk({e.tag, "_pass"}, pass_of(d), e.pass);
            chk({e.tag, "_busy"}, busy_of(d), 0);
            chk({e.tag, "_fa"}, fa_of(d), e.fa);
            chk({e.tag, "_fb"}, fb_of(d), e.fb);
            repeat (3) @(negedge clk);
            chk({e.tag, "_held"}, done_of(d), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  quiet;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_ab", {a0, b0}, 0);
        chk("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ideal comparator with a start re-pulse mid-sweep
        mode0 = 0;
        sb.push_back('{"ideal", 256 * 4 + 1, 0, 1, 0, 0});
        run_sweep(0, 500);

        // eq stuck high: every unequal pair mismatches, first is (0,1)
        mode0 = 1;
        sb.push_back('{"eqstuck", 256 * 4 + 1, 240, 0, 0, FL ? 1 : 0});
        run_sweep(0, -1);

        // st/lt swapped with zero settle time
        mode1 = 2;
        sb.push_back('{"swap", 256 * 2 + 1, 240, 0, 0, FL ? 1 : 0});
        run_sweep(1, -1);

        // abort when pair 100 (a=6, b=4) is on the bus, before it is sampled
        mode0 = 1;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        @(negedge clk) start0 = 1'b0;
        chk("ab_done_clr", done0, 0);
        chk("ab_err_clr", err0, 0);
        chk("ab_fb_clr", fb0, 0);
        cnt = 0;
        while (!(a0 == 4'd6 && b0 == 4'd4) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("ab_reach", {a0, b0}, 8'h64);
        abort0 = 1'b1;
        @(posedge clk);
        @(negedge clk) abort0 = 1'b0;
        chk("ab_busy", busy0, 0);
        chk("ab_ab", {a0, b0}, 0);
        chk("ab_done", done0, 0);
        chk("ab_err", err0, 94);
        chk("ab_fb", fb0, FL ? 1 : 0);
        repeat (5) @(negedge clk);
        chk("ab_idle", busy0, 0);
        chk("ab_hold", err0, 94);
        mode0 = 0;
        sb.push_back('{"post_abort", 256 * 4 + 1, 0, 1, 0, 0});
        run_sweep(0, -1);

        // asynchronous reset in the middle of a failing sweep
        mode0 = 1;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        @(negedge clk) start0 = 1'b0;
        repeat (300) @(negedge clk);
        chk("pre_rst_err", err0 != 9'd0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_ab", {a0, b0}, 0);
        chk("arst_err", err0, 0);
        chk("arst_done", {done0, pass0}, 0);
        chk("arst_fail", {fa0, fb0}, 0);
        @(negedge clk) rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            quiet &= (busy0 == 1'b0) && (a0 == 4'd0) && (b0 == 4'd0) && (done0 == 1'b0);
        end
        chk("post_rst_idle", quiet, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
